// File: rtl/cfg_loader_defs_pkg.sv
// ---------------------------------------------------------------------------
// cfg_loader_defs
//   Shared definitions for the connection-block configuration frame loader:
//   the loader FSM state encoding, the width of one memory-size field, the
//   default tile geometry (six mux memories) and a constant ceil-log2 helper
//   used to work out how many in-memory address bits each memory needs.
//
//   No ports (package).
// ---------------------------------------------------------------------------
package cfg_loader_defs;

  // Loader FSM states, in the order a single bit walks through them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_FINISH
  } loader_state_t;

  // Each memory size is packed into a field of this many bits.
  localparam int SIZE_W = 3;

  // Default tile: six mux memories, memory 0 in the leftmost field.
  localparam int DEFAULT_NUM_MEMS = 6;
  localparam logic [DEFAULT_NUM_MEMS*SIZE_W-1:0] DEFAULT_MEM_SIZES =
    {3'd6, 3'd2, 3'd6, 3'd6, 3'd2, 3'd2};

  // Smallest w with 2**w >= value; only ever evaluated on constants.
  function automatic int ceil_log2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/cfg_addr_sequencer.sv
// ---------------------------------------------------------------------------
// cfg_addr_sequencer
//   Walks every SRAM bit of every mux memory in decoder order and formats the
//   frame address for the bit currently being written.
//
//   Ports:
//     i_clk       programming clock
//     i_rst       asynchronous active-high reset
//     i_clear     restart the walk at memory 0, bit 0
//     i_advance   move to the next bit (stays put after the very last bit)
//     o_lastBit   current bit is the last one of the current memory
//     o_lastMem   current memory is the last memory of the tile
//     o_address   [0:LOCAL_ADDR_W-1] in-memory bit index (MSB-first, left
//                 justified), [LOCAL_ADDR_W:] memory index (MSB-first)
// ---------------------------------------------------------------------------
module cfg_addr_sequencer
  import cfg_loader_defs::*;
#(
  parameter int NUM_MEMS     = DEFAULT_NUM_MEMS,
  parameter int MEM_ADDR_W   = 3,
  parameter int LOCAL_ADDR_W = 3,
  parameter logic [NUM_MEMS*SIZE_W-1:0] MEM_SIZES = DEFAULT_MEM_SIZES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_advance,
  output logic o_lastBit,
  output logic o_lastMem,
  output logic [0:LOCAL_ADDR_W+MEM_ADDR_W-1] o_address
);

  logic [MEM_ADDR_W-1:0]   r_memIdx;
  logic [LOCAL_ADDR_W-1:0] r_bitIdx;
  logic [LOCAL_ADDR_W-1:0] w_lastBitIdx;
  logic [LOCAL_ADDR_W-1:0] w_localAddr;

  // Size of memory idx; memory 0 sits in the most significant field.
  function automatic int sizeOf(input int idx);
    return int'(MEM_SIZES[(NUM_MEMS-1-idx)*SIZE_W +: SIZE_W]);
  endfunction

  // Per-memory lookup of the last bit index and of the address formatting.
  // A memory of size S only uses the top ceil_log2(S) bits of the local
  // field, so the index is shifted up and the unused low bits stay zero.
  always_comb begin
    w_lastBitIdx = '0;
    w_localAddr  = '0;
    for (int i = 0; i < NUM_MEMS; i++) begin
      if (r_memIdx == MEM_ADDR_W'(i)) begin
        w_lastBitIdx = LOCAL_ADDR_W'(sizeOf(i) - 1);
        w_localAddr  = r_bitIdx << (LOCAL_ADDR_W - ceil_log2(sizeOf(i)));
      end
    end
  end

  assign o_lastBit = (r_bitIdx == w_lastBitIdx);
  assign o_lastMem = (r_memIdx == MEM_ADDR_W'(NUM_MEMS - 1));
  assign o_address = {w_localAddr, r_memIdx};

  // Counters: bit index runs within a memory, then rolls into the next
  // memory. After the final bit of the final memory both counters hold,
  // so neither can wrap past its limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_memIdx <= '0;
      r_bitIdx <= '0;
    end else if (i_clear) begin
      r_memIdx <= '0;
      r_bitIdx <= '0;
    end else if (i_advance) begin
      if (!o_lastBit) begin
        r_bitIdx <= r_bitIdx + 1'b1;
      end else if (!o_lastMem) begin
        r_memIdx <= r_memIdx + 1'b1;
        r_bitIdx <= '0;
      end
    end
  end

endmodule

// File: rtl/cbx_config_frame_loader.sv
// ---------------------------------------------------------------------------
// cbx_config_frame_loader
//   Configuration sequencer for a routing connection block. Accepts a serial
//   bitstream over a valid/ready handshake and issues one enable-strobed
//   frame write per SRAM bit, walking all mux memories in decoder order.
//   Each bit takes LOAD -> SETUP -> STROBE; done pulses after the last write.
//
//   Ports:
//     prog_clk   programming clock, all state on the rising edge
//     pReset     asynchronous active-high reset
//     start      single-cycle request to load a tile (ignored while busy)
//     bit_in     configuration bit
//     bit_valid  bit_in is valid
//     bit_ready  loader accepts bit_in this cycle
//     enable     decoder enable / write strobe (one cycle per bit)
//     address    [0:2] in-memory bit index, [3:5] memory index
//     data_in    bit being written
//     busy       load in progress
//     done       one-cycle pulse after the final write
// ---------------------------------------------------------------------------
module cbx_config_frame_loader
  import cfg_loader_defs::*;
#(
  parameter int NUM_MEMS     = DEFAULT_NUM_MEMS,
  parameter int MEM_ADDR_W   = 3,
  parameter int LOCAL_ADDR_W = 3,
  parameter logic [NUM_MEMS*SIZE_W-1:0] MEM_SIZES = DEFAULT_MEM_SIZES
) (
  input  logic prog_clk,
  input  logic pReset,
  input  logic start,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic [0:0] enable,
  output logic [0:LOCAL_ADDR_W+MEM_ADDR_W-1] address,
  output logic [0:0] data_in,
  output logic busy,
  output logic done
);

  localparam int ADDR_W = LOCAL_ADDR_W + MEM_ADDR_W;

  // Reject geometries the decoder or the local address field cannot reach.
  if (NUM_MEMS < 1 || NUM_MEMS > (1 << MEM_ADDR_W)) begin : g_badNumMems
    $error("cbx_config_frame_loader: NUM_MEMS=%0d exceeds a %0d-bit decoder",
           NUM_MEMS, MEM_ADDR_W);
  end
  for (genvar g = 0; g < NUM_MEMS; g++) begin : g_sizeCheck
    localparam int MEM_SIZE = int'(MEM_SIZES[(NUM_MEMS-1-g)*SIZE_W +: SIZE_W]);
    if (MEM_SIZE < 1 || MEM_SIZE > (1 << LOCAL_ADDR_W)) begin : g_badSize
      $error("cbx_config_frame_loader: memory %0d size %0d out of range",
             g, MEM_SIZE);
    end
  end

  loader_state_t r_state;
  loader_state_t w_nextState;

  logic              w_accept;
  logic              w_clear;
  logic              w_advance;
  logic              w_lastBit;
  logic              w_lastMem;
  logic [0:ADDR_W-1] w_seqAddress;
  logic [0:ADDR_W-1] r_address;
  logic              r_data;

  assign w_accept  = (r_state == ST_LOAD) && bit_valid;
  assign w_clear   = (r_state == ST_IDLE) && start;
  assign w_advance = (r_state == ST_STROBE);

  cfg_addr_sequencer #(
    .NUM_MEMS     (NUM_MEMS),
    .MEM_ADDR_W   (MEM_ADDR_W),
    .LOCAL_ADDR_W (LOCAL_ADDR_W),
    .MEM_SIZES    (MEM_SIZES)
  ) u_seq (
    .i_clk     (prog_clk),
    .i_rst     (pReset),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_lastBit (w_lastBit),
    .o_lastMem (w_lastMem),
    .o_address (w_seqAddress)
  );

  // State register.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; start is only looked at in IDLE, which is what makes
  // a start during a load harmless.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE:   if (start)     w_nextState = ST_LOAD;
      ST_LOAD:   if (bit_valid) w_nextState = ST_SETUP;
      ST_SETUP:  w_nextState = ST_STROBE;
      ST_STROBE: w_nextState = (w_lastBit && w_lastMem) ? ST_FINISH : ST_LOAD;
      ST_FINISH: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Address and data are captured on the accepting LOAD edge, so they first
  // appear in SETUP and stay frozen through STROBE and beyond until the next
  // accepted bit. The sequencer has already advanced to this bit's position.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_address <= '0;
      r_data    <= 1'b0;
    end else if (w_accept) begin
      r_address <= w_seqAddress;
      r_data    <= bit_in;
    end
  end

  // Output decode; busy is already low in FINISH so it falls with done.
  always_comb begin
    bit_ready = 1'b0;
    enable    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
      end
      ST_SETUP: begin
        busy = 1'b1;
      end
      ST_STROBE: begin
        enable = 1'b1;
        busy   = 1'b1;
      end
      ST_FINISH: begin
        done = 1'b1;
      end
      default: begin
        bit_ready = 1'b0;
      end
    endcase
  end

  assign address = r_address;
  assign data_in = r_data;

endmodule

// File: tb/tb_cbx_config_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_cbx_config_frame_loader
//   Drives two loaders (default six-memory tile and a two-memory {2,2} tile)
//   and checks every write strobe against an expected frame list derived
//   from the memory sizes and the bitstream.
// ---------------------------------------------------------------------------
module tb_cbx_config_frame_loader;

  logic prog_clk = 1'b0;
  logic pReset;
  logic start;
  logic bit_in;
  logic bit_valid;
  logic sel;

  logic       start1, start2;
  logic       bitReady1, busy1, done1;
  logic       bitReady2, busy2, done2;
  logic [0:0] enable1, dataIn1, enable2, dataIn2;
  logic [0:5] address1, address2;

  logic       vReady, vEnable, vData, vBusy, vDone;
  logic [5:0] vAddr;

  int compared   = 0;
  int mismatched = 0;

  logic       stimBits[$];
  logic [5:0] strobeAddrQ[$];
  logic       strobeDataQ[$];
  logic [5:0] expAddrQ[$];
  logic       expDataQ[$];
  int         doneCount = 0;
  logic       prevEnable = 1'b0;
  logic [5:0] prevAddr = '0;
  logic       prevData = 1'b0;

  int sizes1[6] = '{6, 2, 6, 6, 2, 2};
  int sizes2[2] = '{2, 2};

  always #5 prog_clk = ~prog_clk;

  assign start1  = start & ~sel;
  assign start2  = start & sel;
  assign vReady  = sel ? bitReady2  : bitReady1;
  assign vEnable = sel ? enable2[0] : enable1[0];
  assign vAddr   = sel ? address2   : address1;
  assign vData   = sel ? dataIn2[0] : dataIn1[0];
  assign vBusy   = sel ? busy2      : busy1;
  assign vDone   = sel ? done2      : done1;

  cbx_config_frame_loader u_dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start1),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bitReady1),
    .enable    (enable1),
    .address   (address1),
    .data_in   (dataIn1),
    .busy      (busy1),
    .done      (done1)
  );

  cbx_config_frame_loader #(
    .NUM_MEMS  (2),
    .MEM_SIZES (6'b010_010)
  ) u_dutSmall (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start2),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bitReady2),
    .enable    (enable2),
    .address   (address2),
    .data_in   (dataIn2),
    .busy      (busy2),
    .done      (done2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Strobe monitor: records every write, checks the strobe is one cycle
  // wide and that address/data did not move between SETUP and STROBE.
  always @(negedge prog_clk) begin
    if (!pReset) begin
      if (vEnable) begin
        checkOutput("enable_single_cycle", {31'd0, prevEnable}, 32'd0);
        checkOutput("addr_stable_setup_strobe", {25'd0, prevAddr, prevData},
                    {25'd0, vAddr, vData});
        strobeAddrQ.push_back(vAddr);
        strobeDataQ.push_back(vData);
      end
      if (vDone) doneCount++;
    end
    prevEnable = vEnable;
    prevAddr   = vAddr;
    prevData   = vData;
  end

  // Reference frame list: memories in order, bits in order, local index
  // left-justified in a 3-bit field of ceil(log2(size)) used bits.
  task automatic buildExpected(input logic s);
    int n, k, w, sz;
    expAddrQ.delete();
    expDataQ.delete();
    k = 0;
    n = s ? 2 : 6;
    for (int m = 0; m < n; m++) begin
      sz = s ? sizes2[m] : sizes1[m];
      w = 0;
      while ((1 << w) < sz) w++;
      for (int b = 0; b < sz; b++) begin
        expAddrQ.push_back(6'(((b << (3 - w)) * 8) + m));
        expDataQ.push_back(stimBits[k]);
        k++;
      end
    end
  endtask

  task automatic fillBits(input int n, input bit useFixed, input logic [23:0] fixedBits);
    stimBits.delete();
    for (int i = 0; i < n; i++) begin
      stimBits.push_back(useFixed ? fixedBits[23 - i] : 1'($urandom_range(0, 1)));
    end
  endtask

  // mode 0: valid always high, 1: valid one cycle in three, 2: random valid.
  task automatic applyStimulus(input logic s, input int mode, input int resetAt,
                               input int restartAt, input int expDone);
    int cyc, ptr, strobes, doneCyc;
    bit aborted, pulsed;
    sel = s;
    strobeAddrQ.delete();
    strobeDataQ.delete();
    doneCount = 0;
    ptr = 0; strobes = 0; doneCyc = 0; aborted = 0; pulsed = 0;
    buildExpected(s);
    @(negedge prog_clk);
    start = 1'b1;
    bit_valid = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 1000 && doneCyc == 0 && !aborted) begin
      if (vEnable) strobes++;
      if (vDone) begin
        doneCyc = cyc;
        checkOutput("busy_low_at_done", {31'd0, vBusy}, 32'd0);
      end else if (resetAt > 0 && vEnable && strobes == resetAt) begin
        #1 pReset = 1'b1;
        #1;
        checkOutput("async_reset_enable", {31'd0, vEnable}, 32'd0);
        checkOutput("async_reset_address", {26'd0, vAddr}, 32'd0);
        checkOutput("async_reset_data", {31'd0, vData}, 32'd0);
        checkOutput("async_reset_busy", {31'd0, vBusy}, 32'd0);
        checkOutput("async_reset_ready", {31'd0, vReady}, 32'd0);
        @(negedge prog_clk);
        pReset = 1'b0;
        aborted = 1;
      end else begin
        case (mode)
          0:       bit_valid = 1'b1;
          1:       bit_valid = (cyc % 3 == 0);
          default: bit_valid = 1'($urandom_range(0, 1));
        endcase
        bit_in = (ptr < stimBits.size()) ? stimBits[ptr] : 1'b0;
        if (restartAt >= 0 && ptr == restartAt && !pulsed) begin
          start = 1'b1;
          pulsed = 1;
        end else begin
          start = 1'b0;
        end
        if (bit_valid && vReady) ptr++;
        @(negedge prog_clk);
        cyc++;
      end
    end
    start = 1'b0;
    bit_valid = 1'b0;
    if (!aborted) begin
      checkOutput("done_seen", {31'd0, doneCyc != 0}, 32'd1);
      if (expDone > 0) checkOutput("done_cycle", doneCyc, expDone);
      repeat (3) @(negedge prog_clk);
      checkOutput("done_pulse_count", doneCount, 1);
      checkOutput("busy_after_done", {31'd0, vBusy}, 32'd0);
      checkOutput("strobe_count", strobeAddrQ.size(), expAddrQ.size());
      for (int i = 0; i < expAddrQ.size() && i < strobeAddrQ.size(); i++) begin
        checkOutput($sformatf("strobe%0d_addr", i), {26'd0, strobeAddrQ[i]},
                    {26'd0, expAddrQ[i]});
        checkOutput($sformatf("strobe%0d_data", i), {31'd0, strobeDataQ[i]},
                    {31'd0, expDataQ[i]});
      end
    end
  endtask

  initial begin
    pReset = 1'b1;
    start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge prog_clk);
    checkOutput("reset_enable", {30'd0, enable1, enable2}, 32'd0);
    checkOutput("reset_address", {20'd0, address1, address2}, 32'd0);
    checkOutput("reset_data", {30'd0, dataIn1, dataIn2}, 32'd0);
    checkOutput("reset_ready", {30'd0, bitReady1, bitReady2}, 32'd0);
    checkOutput("reset_busy_done", {28'd0, busy1, busy2, done1, done2}, 32'd0);
    @(negedge prog_clk);
    pReset = 1'b0;

    $display("[TB] idle safety: valid without start");
    bit_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge prog_clk);
      checkOutput("idle_ready", {31'd0, vReady}, 32'd0);
      checkOutput("idle_enable", {31'd0, vEnable}, 32'd0);
    end
    bit_valid = 1'b0;

    $display("[TB] full default load, fixed pattern");
    fillBits(24, 1'b1, 24'hA5C3F0);
    applyStimulus(1'b0, 0, 0, -1, 73);

    $display("[TB] backpressure, fixed pattern");
    applyStimulus(1'b0, 1, 0, -1, 0);

    $display("[TB] random bits, random valid");
    fillBits(24, 1'b0, 24'h0);
    applyStimulus(1'b0, 2, 0, -1, 0);

    $display("[TB] reset during tenth strobe");
    fillBits(24, 1'b0, 24'h0);
    applyStimulus(1'b0, 0, 10, -1, 0);
    @(negedge prog_clk);
    checkOutput("post_reset_idle_busy", {31'd0, vBusy}, 32'd0);

    $display("[TB] reload after reset");
    fillBits(24, 1'b0, 24'h0);
    applyStimulus(1'b0, 0, 0, -1, 73);

    $display("[TB] start while busy");
    fillBits(24, 1'b0, 24'h0);
    applyStimulus(1'b0, 0, 0, 5, 73);

    $display("[TB] two-memory tile");
    fillBits(4, 1'b0, 24'h0);
    applyStimulus(1'b1, 0, 0, -1, 13);
    fillBits(4, 1'b0, 24'h0);
    applyStimulus(1'b1, 2, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
